// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcode constants, instruction field
// positions, control-bundle bit indices and a field-decode helper.
package mips_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned IMM_W      = 16;

    // Instruction field positions (LSB of each field)
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned IMM_LSB    = 0;

    // Opcodes
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    // Control-bundle bit indices: M bits low, EX bits middle, WB bits high
    localparam int unsigned CTRL_MEMREAD  = 0;
    localparam int unsigned CTRL_MEMWRITE = 1;
    localparam int unsigned CTRL_BRANCH   = 2;
    localparam int unsigned CTRL_ALUSRC   = 3;
    localparam int unsigned CTRL_ALUOP0   = 4;
    localparam int unsigned CTRL_REGDST   = 5;
    localparam int unsigned CTRL_REGWRITE = 6;
    localparam int unsigned CTRL_MEMTOREG = 7;

    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic [IMM_W-1:0]      imm;
    } instr_fields_t;

    function automatic instr_fields_t decode_fields(input logic [INSTR_W-1:0] instr);
        instr_fields_t f;
        f.opcode = instr[OPCODE_LSB +: OPCODE_W];
        f.rs     = instr[RS_LSB +: REG_ADDR_W];
        f.rt     = instr[RT_LSB +: REG_ADDR_W];
        f.rd     = instr[RD_LSB +: REG_ADDR_W];
        f.imm    = instr[IMM_LSB +: IMM_W];
        return f;
    endfunction

endpackage

// File: rtl/mips_frontend_pipe_if.sv
// Bus bundle of the MIPS front-end pipe: instruction memory, control unit,
// register file, redirect input and the ID/EX outputs.
// master: pipeline side; slave: surrounding datapath / memories.
interface mips_frontend_pipe_if
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
);
    logic [ADDR_W-1:0]     imem_addr;
    logic [INSTR_W-1:0]    imem_rdata;
    logic [OPCODE_W-1:0]   id_opcode;
    logic [CTRL_W-1:0]     ctrl_in;
    logic [REG_ADDR_W-1:0] rf_rs_addr;
    logic [REG_ADDR_W-1:0] rf_rt_addr;
    logic [DATA_W-1:0]     rf_rs_data;
    logic [DATA_W-1:0]     rf_rt_data;
    logic                  redirect_valid;
    logic [ADDR_W-1:0]     redirect_pc;
    logic                  stall;
    logic                  ex_valid;
    logic [CTRL_W-1:0]     ex_ctrl;
    logic [ADDR_W-1:0]     ex_pc4;
    logic [DATA_W-1:0]     ex_rs_data;
    logic [DATA_W-1:0]     ex_rt_data;
    logic [DATA_W-1:0]     ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [15:0]           stall_cnt;

    modport master (
        output imem_addr, id_opcode, rf_rs_addr, rf_rt_addr, stall,
               ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, stall_cnt,
        input  imem_rdata, ctrl_in, rf_rs_data, rf_rt_data,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, id_opcode, rf_rs_addr, rf_rt_addr, stall,
               ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, stall_cnt,
        output imem_rdata, ctrl_in, rf_rs_data, rf_rt_data,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector.
// Ports: id_valid/id_rs/id_rt (IF/ID), ex_valid/ex_memread/ex_rt (ID/EX),
//        redirect_valid (taken branch/jump), stall (hazard this cycle).
module hazard_detect
    import mips_pkg::*;
(
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  ex_valid,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  redirect_valid,
    output logic                  stall
);
    logic reg_match;

    // r0 is hardwired zero, so a load into it never creates a dependency
    assign reg_match = (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    // A redirect flushes the dependent instruction, so it cancels the stall
    assign stall = id_valid && ex_valid && ex_memread && reg_match && !redirect_valid;
endmodule

// File: rtl/mips_frontend_pipe.sv
// MIPS IF/ID/EX front end: PC register, IF/ID and ID/EX pipeline registers,
// immediate extension, load-use stall and stall cycle counter.
// Ports: clk, rst_n (async active-low), bus (mips_frontend_pipe_if.master):
//   imem_addr/imem_rdata fetch, id_opcode/ctrl_in control lookup,
//   rf_* register read, redirect_valid/redirect_pc, stall, ex_* ID/EX
//   register outputs, stall_cnt saturating stall counter.
module mips_frontend_pipe
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       CTRL_W      = 8,
    parameter int unsigned       MEMREAD_BIT = CTRL_MEMREAD,
    parameter logic [ADDR_W-1:0] PC_RESET    = '0,
    parameter bit                SIGN_EXT    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_frontend_pipe_if.master bus
);
    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    logic [ADDR_W-1:0]     pc_q;
    logic [ADDR_W-1:0]     pc4_c;

    logic                  if_valid_q;
    logic [ADDR_W-1:0]     if_pc4_q;
    logic [INSTR_W-1:0]    if_instr_q;
    instr_fields_t         if_f_c;
    logic [DATA_W-1:0]     imm_ext_c;

    logic                  stall_c;

    logic                  ex_valid_q;
    logic [CTRL_W-1:0]     ex_ctrl_q;
    logic [ADDR_W-1:0]     ex_pc4_q;
    logic [DATA_W-1:0]     ex_rs_data_q;
    logic [DATA_W-1:0]     ex_rt_data_q;
    logic [DATA_W-1:0]     ex_imm_q;
    logic [REG_ADDR_W-1:0] ex_rs_q;
    logic [REG_ADDR_W-1:0] ex_rt_q;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic [15:0]           stall_cnt_q;

    // Sequential PC increment, wraps naturally at ADDR_W bits
    assign pc4_c  = pc_q + ADDR_W'(4);
    assign if_f_c = decode_fields(if_instr_q);

    // Immediate widening: replicate bit 15 or zero-fill
    assign imm_ext_c = SIGN_EXT ? DATA_W'($signed(if_f_c.imm)) : DATA_W'(if_f_c.imm);

    hazard_detect u_hazard (
        .id_valid       (if_valid_q),
        .id_rs          (if_f_c.rs),
        .id_rt          (if_f_c.rt),
        .ex_valid       (ex_valid_q),
        .ex_memread     (ex_ctrl_q[MEMREAD_BIT]),
        .ex_rt          (ex_rt_q),
        .redirect_valid (bus.redirect_valid),
        .stall          (stall_c)
    );

    // PC: redirect > stall hold > sequential
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_RESET;
        end else if (bus.redirect_valid) begin
            pc_q <= bus.redirect_pc;
        end else if (!stall_c) begin
            pc_q <= pc4_c;
        end
    end

    // IF/ID: flushed on redirect, held on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid_q <= 1'b0;
            if_pc4_q   <= '0;
            if_instr_q <= '0;
        end else if (bus.redirect_valid) begin
            if_valid_q <= 1'b0;
            if_pc4_q   <= '0;
            if_instr_q <= '0;
        end else if (!stall_c) begin
            if_valid_q <= 1'b1;
            if_pc4_q   <= pc4_c;
            if_instr_q <= bus.imem_rdata;
        end
    end

    // ID/EX: bubble on redirect or stall, otherwise take decoded IF/ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_pc4_q     <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
        end else if (bus.redirect_valid || stall_c) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_pc4_q     <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
        end else begin
            ex_valid_q   <= if_valid_q;
            ex_ctrl_q    <= if_valid_q ? bus.ctrl_in : '0;
            ex_pc4_q     <= if_pc4_q;
            ex_rs_data_q <= bus.rf_rs_data;
            ex_rt_data_q <= bus.rf_rt_data;
            ex_imm_q     <= imm_ext_c;
            ex_rs_q      <= if_f_c.rs;
            ex_rt_q      <= if_f_c.rt;
            ex_rd_q      <= if_f_c.rd;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_c && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.id_opcode  = if_f_c.opcode;
    assign bus.rf_rs_addr = if_f_c.rs;
    assign bus.rf_rt_addr = if_f_c.rt;
    assign bus.stall      = stall_c;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.ex_pc4     = ex_pc4_q;
    assign bus.ex_rs_data = ex_rs_data_q;
    assign bus.ex_rt_data = ex_rt_data_q;
    assign bus.ex_imm     = ex_imm_q;
    assign bus.ex_rs      = ex_rs_q;
    assign bus.ex_rt      = ex_rt_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.stall_cnt  = stall_cnt_q;
endmodule
